// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default register-file geometry, the hard-wired
// zero register index and the state encoding of the register bank sequencer.
// No ports; imported by the sequencer.
package cpu_pkg;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_REG_ADDR_WIDTH = 4;

  // Architectural index of the register that reads as zero.
  localparam int ZERO_REG_IDX = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ1 = 3'd2,
    ST_READ2 = 3'd3,
    ST_RESP  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/RegisterBank.sv
// Single-port register file: one index shared by read and write, combinational
// read of regNum, write of dataIn on the clock edge when writeEnable is high.
// Ports: clk, reset (synchronous, active-high, clears all registers), regNum,
// dataIn, writeEnable, dataOut.
module RegisterBank #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REG_ADDR_WIDTH-1:0] regNum,
  input  logic [DATA_WIDTH-1:0]     dataIn,
  input  logic                      writeEnable,
  output logic [DATA_WIDTH-1:0]     dataOut
);

  localparam int NREGS = 1 << REG_ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (writeEnable) begin
      regs_q[regNum] <= dataIn;
    end
  end

  assign dataOut = regs_q[regNum];

endmodule

// File: rtl/register_bank_sequencer.sv
// Serialises one register-file transaction (optional write of rd, reads of rs1
// and rs2) over a single-port RegisterBank, in write-first or read-first order.
// Latency: accept cycle to rsp_valid is 3 cycles (read only) or 4 (with write).
// Backpressure: req_ready only in IDLE; the response is held until rsp_ready.
// Ports: clk, reset (sync, active-low); req_* request channel (valid/ready);
// rsp_* response channel (valid/ready); bank_* drive/observe the RegisterBank;
// busy is high whenever a transaction is in flight.
module register_bank_sequencer
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter bit WRITE_FIRST    = 1'b1,
  parameter bit ZERO_REG       = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [REG_ADDR_WIDTH-1:0] req_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] req_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] req_rd,
  input  logic                      req_we,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rs1_data,
  output logic [DATA_WIDTH-1:0]     rsp_rs2_data,
  output logic [REG_ADDR_WIDTH-1:0] bank_regNum,
  output logic [DATA_WIDTH-1:0]     bank_dataIn,
  output logic                      bank_we,
  input  logic [DATA_WIDTH-1:0]     bank_dataOut,
  output logic                      busy
);

  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_IDX = REG_ADDR_WIDTH'(ZERO_REG_IDX);

  seq_state_t                  state_q;
  logic [REG_ADDR_WIDTH-1:0]   rs1_q;
  logic [REG_ADDR_WIDTH-1:0]   rs2_q;
  logic [REG_ADDR_WIDTH-1:0]   rd_q;
  logic                        we_q;
  logic [DATA_WIDTH-1:0]       wdata_q;
  logic [DATA_WIDTH-1:0]       rs1_data_q;
  logic [DATA_WIDTH-1:0]       rs2_data_q;
  logic                        rsp_valid_q;

  logic                        rs1_is_zero;
  logic                        rs2_is_zero;
  logic                        write_phase;

  assign rs1_is_zero = ZERO_REG && (rs1_q == ZERO_IDX);
  assign rs2_is_zero = ZERO_REG && (rs2_q == ZERO_IDX);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // req_ready is high whenever we are here out of reset
          if (req_valid) begin
            rs1_q   <= req_rs1;
            rs2_q   <= req_rs2;
            rd_q    <= req_rd;
            we_q    <= req_we;
            wdata_q <= req_wdata;
            if (req_we && WRITE_FIRST) begin
              state_q <= ST_WRITE;
            end else begin
              state_q <= ST_READ1;
            end
          end
        end
        ST_WRITE: begin
          if (WRITE_FIRST) begin
            state_q <= ST_READ1;
          end else begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
          end
        end
        ST_READ1: begin
          rs1_data_q <= rs1_is_zero ? '0 : bank_dataOut;
          state_q    <= ST_READ2;
        end
        ST_READ2: begin
          rs2_data_q <= rs2_is_zero ? '0 : bank_dataOut;
          if (we_q && !WRITE_FIRST) begin
            state_q <= ST_WRITE;
          end else begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Bank port decode. A write to the zero register still occupies the WRITE
  // cycle so latency does not depend on rd, it simply never raises bank_we.
  always_comb begin
    bank_regNum = '0;
    bank_dataIn = '0;
    write_phase = 1'b0;
    case (state_q)
      ST_WRITE: begin
        bank_regNum = rd_q;
        bank_dataIn = wdata_q;
        write_phase = !(ZERO_REG && (rd_q == ZERO_IDX));
      end
      ST_READ1: bank_regNum = rs1_q;
      ST_READ2: bank_regNum = rs2_q;
      default: ;
    endcase
  end

  // Reset gates the write strobe directly: a reset landing in the WRITE cycle
  // must not commit to the bank, even though state_q only clears at the edge.
  assign bank_we = write_phase && reset;

  // Gated by reset so the request side sees "not ready" while reset is held.
  assign req_ready = (state_q == ST_IDLE) && reset;

  assign busy         = (state_q != ST_IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rs1_data = rs1_data_q;
  assign rsp_rs2_data = rs2_data_q;

endmodule

// File: tb/tb_register_bank_sequencer.sv
module tb_register_bank_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid_a, req_valid_b;
  logic [3:0]  req_rs1, req_rs2, req_rd;
  logic        req_we;
  logic [31:0] req_wdata;
  logic        rsp_ready;

  // instance A: WRITE_FIRST=1, instance B: WRITE_FIRST=0
  logic        req_ready_a, rsp_valid_a, bank_we_a, busy_a;
  logic [31:0] rs1_a, rs2_a, bank_din_a, bank_dout_a;
  logic [3:0]  bank_reg_a;
  logic        req_ready_b, rsp_valid_b, bank_we_b, busy_b;
  logic [31:0] rs1_b, rs2_b, bank_din_b, bank_dout_b;
  logic [3:0]  bank_reg_b;

  register_bank_sequencer #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(4), .WRITE_FIRST(1'b1), .ZERO_REG(1'b1)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .req_we(req_we), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
    .rsp_rs1_data(rs1_a), .rsp_rs2_data(rs2_a),
    .bank_regNum(bank_reg_a), .bank_dataIn(bank_din_a), .bank_we(bank_we_a),
    .bank_dataOut(bank_dout_a), .busy(busy_a)
  );

  RegisterBank #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(4)) bank_a (
    .clk(clk), .reset(~reset), .regNum(bank_reg_a), .dataIn(bank_din_a),
    .writeEnable(bank_we_a), .dataOut(bank_dout_a)
  );

  register_bank_sequencer #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(4), .WRITE_FIRST(1'b0), .ZERO_REG(1'b1)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .req_we(req_we), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
    .rsp_rs1_data(rs1_b), .rsp_rs2_data(rs2_b),
    .bank_regNum(bank_reg_b), .bank_dataIn(bank_din_b), .bank_we(bank_we_b),
    .bank_dataOut(bank_dout_b), .busy(busy_b)
  );

  RegisterBank #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(4)) bank_b (
    .clk(clk), .reset(~reset), .regNum(bank_reg_b), .dataIn(bank_din_b),
    .writeEnable(bank_we_b), .dataOut(bank_dout_b)
  );

  // Selected-instance views used by the transaction task
  logic        cur;
  logic        cur_req_ready, cur_rsp_valid, cur_busy;
  logic [31:0] cur_rs1, cur_rs2;
  assign cur_req_ready = cur ? req_ready_b : req_ready_a;
  assign cur_rsp_valid = cur ? rsp_valid_b : rsp_valid_a;
  assign cur_busy      = cur ? busy_b      : busy_a;
  assign cur_rs1       = cur ? rs1_b       : rs1_a;
  assign cur_rs2       = cur ? rs2_b       : rs2_a;

  // Committed bank writes (strobe seen high at a clock edge)
  int we_pulses_a = 0;
  int we_pulses_b = 0;
  always @(posedge clk) begin
    if (bank_we_a === 1'b1) we_pulses_a++;
    if (bank_we_b === 1'b1) we_pulses_b++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with the instance back in IDLE.
  task automatic transact(input logic inst, input logic [3:0] rs1, input logic [3:0] rs2,
                          input logic [3:0] rd, input logic we, input logic [31:0] wd,
                          input int exp_lat, input logic [31:0] exp1, input logic [31:0] exp2,
                          input int stall, input string tag);
    int n;
    cur       = inst;
    req_rs1   = rs1;
    req_rs2   = rs2;
    req_rd    = rd;
    req_we    = we;
    req_wdata = wd;
    rsp_ready = (stall == 0);
    if (inst) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    #1;
    chk({tag, " req_ready"}, 32'(cur_req_ready), 32'd1);
    @(posedge clk);
    #1;
    // Scramble the request fields after the accept edge; the DUT must ignore them
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    req_rs1     = ~rs1;
    req_rs2     = ~rs2;
    req_rd      = ~rd;
    req_we      = ~we;
    req_wdata   = ~wd;
    n = 1;
    while (cur_rsp_valid !== 1'b1 && n < 16) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(exp_lat));
    @(negedge clk);
    chk({tag, " rs1_data"}, cur_rs1, exp1);
    chk({tag, " rs2_data"}, cur_rs2, exp2);
    for (int i = 0; i < stall; i++) begin
      if (inst) req_valid_b = 1'b1; else req_valid_a = 1'b1;
      @(negedge clk);
      chk({tag, " stall rsp_valid"}, 32'(cur_rsp_valid), 32'd1);
      chk({tag, " stall rs1_data"}, cur_rs1, exp1);
      chk({tag, " stall rs2_data"}, cur_rs2, exp2);
      chk({tag, " stall req_ready"}, 32'(cur_req_ready), 32'd0);
    end
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    rsp_ready   = 1'b1;
    @(negedge clk);
    chk({tag, " done rsp_valid"}, 32'(cur_rsp_valid), 32'd0);
    chk({tag, " done busy"}, 32'(cur_busy), 32'd0);
    chk({tag, " done req_ready"}, 32'(cur_req_ready), 32'd1);
  endtask

  int snap;

  initial begin
    reset       = 1'b0;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    req_rs1     = '0;
    req_rs2     = '0;
    req_rd      = '0;
    req_we      = 1'b0;
    req_wdata   = '0;
    rsp_ready   = 1'b0;
    cur         = 1'b0;

    // 1: reset held for three cycles
    repeat (3) begin
      @(negedge clk);
      chk("reset req_ready_a", 32'(req_ready_a), 32'd0);
      chk("reset req_ready_b", 32'(req_ready_b), 32'd0);
      chk("reset rsp_valid_a", 32'(rsp_valid_a), 32'd0);
      chk("reset bank_we_a", 32'(bank_we_a), 32'd0);
    end
    chk("reset busy_a", 32'(busy_a), 32'd0);
    chk("reset bank_regNum_a", 32'(bank_reg_a), 32'd0);
    chk("reset rs1_data_a", rs1_a, 32'd0);
    reset = 1'b1;
    #1;
    chk("post reset req_ready_a", 32'(req_ready_a), 32'd1);
    chk("post reset req_ready_b", 32'(req_ready_b), 32'd1);
    @(negedge clk);
    chk("idle bank_dataIn_a", bank_din_a, 32'd0);

    // 2: write-first, rd == rs1 sees the new value
    snap = we_pulses_a;
    transact(1'b0, 4'd5, 4'd0, 4'd5, 1'b1, 32'hDEADBEEF, 4, 32'hDEADBEEF, 32'd0, 0, "wf_write_x5");
    chk("wf_write_x5 we pulses", 32'(we_pulses_a - snap), 32'd1);

    // 3: write to x0 is dropped but keeps the WRITE cycle
    snap = we_pulses_a;
    transact(1'b0, 4'd0, 4'd5, 4'd0, 1'b1, 32'h12345678, 4, 32'd0, 32'hDEADBEEF, 0, "x0_write");
    chk("x0_write we pulses", 32'(we_pulses_a - snap), 32'd0);
    chk("x0_write bank x0", bank_a.regs_q[0], 32'd0);

    // 5: rs1 == rs2, read only, response stalled for 10 cycles
    transact(1'b0, 4'd5, 4'd5, 4'd9, 1'b0, 32'h0, 3, 32'hDEADBEEF, 32'hDEADBEEF, 10, "stall_rd");

    // 4: read-first instance returns old value, then new value
    transact(1'b1, 4'd0, 4'd0, 4'd3, 1'b1, 32'd1, 4, 32'd0, 32'd0, 0, "rf_init_x3");
    transact(1'b1, 4'd3, 4'd5, 4'd3, 1'b1, 32'd2, 4, 32'd1, 32'd0, 0, "rf_old_x3");
    transact(1'b1, 4'd3, 4'd3, 4'd0, 1'b0, 32'h0, 3, 32'd2, 32'd2, 0, "rf_new_x3");

    // 6: reset asserted in the WRITE cycle
    cur         = 1'b0;
    req_rs1     = 4'd7;
    req_rs2     = 4'd7;
    req_rd      = 4'd7;
    req_we      = 1'b1;
    req_wdata   = 32'hCAFEF00D;
    rsp_ready   = 1'b1;
    req_valid_a = 1'b1;
    snap        = we_pulses_a;
    @(posedge clk);
    #1;
    req_valid_a = 1'b0;
    reset       = 1'b0;
    @(negedge clk);
    chk("midreset in write (regNum)", 32'(bank_reg_a), 32'd7);
    chk("midreset bank_we", 32'(bank_we_a), 32'd0);
    @(negedge clk);
    chk("midreset we pulses", 32'(we_pulses_a - snap), 32'd0);
    chk("midreset busy", 32'(busy_a), 32'd0);
    chk("midreset rsp_valid", 32'(rsp_valid_a), 32'd0);
    chk("midreset x7", bank_a.regs_q[7], 32'd0);
    reset = 1'b1;
    @(negedge clk);
    transact(1'b0, 4'd7, 4'd5, 4'd0, 1'b0, 32'h0, 3, 32'd0, 32'd0, 0, "post_midreset_rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
